// File: rtl/ccd_acq_scheduler.sv
// Acquisition sequencer for the ILX511B timing generator: trigger, frame pixel
// count, inter-scan gap, batch bookkeeping and a millisecond readout watchdog.
module ccd_acq_scheduler #(
  parameter int PIXELS           = 2048,
  parameter int TRIG_WIDTH       = 4,
  parameter int GAP_CYCLES       = 16,
  parameter int TICKS_PER_MS     = 50000,
  parameter int TIMEOUT_EXTRA_MS = 20
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] cfg_int_ms,
  input  logic [7:0]  cfg_scans,
  input  logic        cfg_continuous,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        pix_valid,
  output logic        aqui_src,
  output logic [15:0] int_time,
  output logic        scan_done,
  output logic        batch_done,
  output logic [7:0]  scan_idx,
  output logic        busy,
  output logic        timeout_err
);
  localparam int PIX_W = $clog2(PIXELS + 1);
  localparam int TRW   = $clog2(TRIG_WIDTH + 1);
  localparam int GW    = $clog2(GAP_CYCLES + 1);
  localparam int PRE_W = $clog2(TICKS_PER_MS + 1);
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIXELS - 1);
  localparam logic [TRW-1:0]   TRIG_LEN  = TRW'(TRIG_WIDTH);
  localparam logic [GW-1:0]    GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICKS_PER_MS - 1);

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_FRAME, S_GAP} state_t;

  state_t           state_q;
  logic [PIX_W-1:0] pix_cnt_q;
  logic [TRW-1:0]   trig_cnt_q;
  logic [GW-1:0]    gap_cnt_q;
  logic [PRE_W-1:0] pre_q;
  logic [16:0]      ms_q;
  logic [7:0]       scans_q;
  logic             cont_q, stop_pend_q;
  logic             aqui_q, scan_done_q, batch_done_q, busy_q, timeout_q;
  logic [15:0]      int_time_q;
  logic [7:0]       scan_idx_q;

  logic [7:0]  scans_d;
  logic [16:0] ms_limit;
  assign scans_d  = (cfg_scans == 8'd0) ? 8'd1 : cfg_scans;
  assign ms_limit = {1'b0, int_time_q} + 17'(TIMEOUT_EXTRA_MS);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      pix_cnt_q    <= '0;
      trig_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      pre_q        <= '0;
      ms_q         <= '0;
      scans_q      <= '0;
      cont_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      aqui_q       <= 1'b0;
      scan_done_q  <= 1'b0;
      batch_done_q <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      int_time_q   <= '0;
      scan_idx_q   <= '0;
    end else begin
      scan_done_q  <= 1'b0;
      batch_done_q <= 1'b0;
      if (cmd_stop && state_q != S_IDLE) stop_pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (cmd_start && !cmd_stop) begin
            int_time_q <= cfg_int_ms;
            scans_q    <= scans_d;
            cont_q     <= cfg_continuous;
            timeout_q  <= 1'b0;
            scan_idx_q <= '0;
            trig_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_TRIG;
          end
        end
        S_TRIG: begin
          // First TRIG cycle raises the level, so the pulse is exactly TRIG_WIDTH long.
          if (trig_cnt_q == TRIG_LEN) begin
            aqui_q    <= 1'b0;
            pix_cnt_q <= '0;
            pre_q     <= '0;
            ms_q      <= '0;
            state_q   <= S_FRAME;
          end else begin
            aqui_q     <= 1'b1;
            trig_cnt_q <= trig_cnt_q + TRW'(1);
          end
        end
        S_FRAME: begin
          if (pre_q == TICK_LAST) begin
            pre_q <= '0;
            ms_q  <= ms_q + 17'd1;
          end else begin
            pre_q <= pre_q + PRE_W'(1);
          end
          if (ms_q > ms_limit) begin
            timeout_q   <= 1'b1;
            busy_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            state_q     <= S_IDLE;
          end else if (pix_valid) begin
            if (pix_cnt_q == PIX_LAST) begin
              scan_done_q <= 1'b1;
              gap_cnt_q   <= '0;
              state_q     <= S_GAP;
            end else begin
              pix_cnt_q <= pix_cnt_q + PIX_W'(1);
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            trig_cnt_q <= '0;
            if (stop_pend_q) begin
              stop_pend_q <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= S_IDLE;
            end else if (scan_idx_q == scans_q - 8'd1) begin
              batch_done_q <= 1'b1;
              if (cont_q) begin
                int_time_q <= cfg_int_ms;
                scans_q    <= scans_d;
                cont_q     <= cfg_continuous;
                scan_idx_q <= '0;
                state_q    <= S_TRIG;
              end else begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end else begin
              scan_idx_q <= scan_idx_q + 8'd1;
              state_q    <= S_TRIG;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign aqui_src    = aqui_q;
  assign int_time    = int_time_q;
  assign scan_done   = scan_done_q;
  assign batch_done  = batch_done_q;
  assign scan_idx    = scan_idx_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;
endmodule
